// File: rtl/lsu_dtcm_master.sv
// LSU-side DTCM initiator: takes one decoded load/store from EX, issues a single-cycle DTCM request,
// waits for the response (with timeout) and returns an extended writeback result or an error.
module lsu_dtcm_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int TO_W      = 4,
  parameter int TIMEOUT   = 15,
  parameter int CHK_ALIGN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid_i,
  output logic          ex_ready_o,
  input  logic          ex_load_i,
  input  logic          ex_store_i,
  input  logic [1:0]    ex_size_i,
  input  logic          ex_unsigned_i,
  input  logic [AW-1:0] ex_addr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic [4:0]    ex_rd_i,
  output logic          req_to_dtcm,
  output logic          load_to_dtcm,
  output logic          store_to_dtcm,
  output logic [AW-1:0] addr_to_dtcm,
  output logic [DW-1:0] store_data_to_dtcm,
  output logic [3:0]    store_mask_to_dtcm,
  input  logic          res_from_dtcm,
  input  logic [DW-1:0] data_from_dtcm,
  output logic          wb_valid_o,
  output logic          wb_we_o,
  output logic [4:0]    wb_rd_o,
  output logic [DW-1:0] wb_data_o,
  output logic          err_o,
  output logic [1:0]    err_cause_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] d, input logic [1:0] sz,
                                                input logic uns);
    case (sz)
      2'b00:   load_extend = {{(DW-8){~uns & d[7]}}, d[7:0]};
      2'b01:   load_extend = {{(DW-16){~uns & d[15]}}, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction

  // Mask bits mark the byte lanes that are NOT written.
  function automatic logic [3:0] size_to_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_to_mask = 4'b1110;
      2'b01:   size_to_mask = 4'b1100;
      default: size_to_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] store_trim(input logic [DW-1:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   store_trim = {{(DW-8){1'b0}}, d[7:0]};
      2'b01:   store_trim = {{(DW-16){1'b0}}, d[15:0]};
      default: store_trim = d;
    endcase
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [1:0]      cause_nxt_s;
  logic [TO_W-1:0] cnt_r;
  logic [TO_W-1:0] cnt_inc_s;
  logic            ready_r;
  logic            accept_s;
  logic            illegal_s;
  logic            misalign_s;
  logic            timeout_s;
  logic            op_load_r;
  logic            op_unsigned_r;
  logic [1:0]      op_size_r;
  logic [4:0]      op_rd_r;

  assign ex_ready_o = ready_r;

  // Decode acceptance, op legality, alignment and timeout conditions.
  always_comb begin
    accept_s   = ex_valid_i & ready_r;
    illegal_s  = (ex_load_i == ex_store_i) | (ex_size_i == 2'b11);
    misalign_s = (CHK_ALIGN != 0) &
                 (((ex_size_i == 2'b01) & ex_addr_i[0]) |
                  ((ex_size_i == 2'b10) & (ex_addr_i[1:0] != 2'b00)));
    cnt_inc_s  = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    timeout_s  = (cnt_inc_s == TIMEOUT[TO_W-1:0]);
  end

  // Next-state logic; RESP also accepts so back-to-back ops run every three cycles.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = CAUSE_NONE;
    case (state_r)
      S_IDLE, S_RESP: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_nxt_s = S_RESP;
            cause_nxt_s = CAUSE_ILLEGAL;
          end else if (misalign_s) begin
            state_nxt_s = S_RESP;
            cause_nxt_s = CAUSE_MISALIGN;
          end else begin
            state_nxt_s = S_REQ;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (res_from_dtcm) begin
          state_nxt_s = S_RESP;
        end else if (timeout_s) begin
          state_nxt_s = S_RESP;
          cause_nxt_s = CAUSE_TIMEOUT;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, op capture and all registered outputs; every pulse output defaults low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= S_IDLE;
      cnt_r              <= {TO_W{1'b0}};
      ready_r            <= 1'b1;
      op_load_r          <= 1'b0;
      op_unsigned_r      <= 1'b0;
      op_size_r          <= 2'b00;
      op_rd_r            <= 5'd0;
      req_to_dtcm        <= 1'b0;
      load_to_dtcm       <= 1'b0;
      store_to_dtcm      <= 1'b0;
      addr_to_dtcm       <= {AW{1'b0}};
      store_data_to_dtcm <= {DW{1'b0}};
      store_mask_to_dtcm <= 4'b0000;
      wb_valid_o         <= 1'b0;
      wb_we_o            <= 1'b0;
      wb_rd_o            <= 5'd0;
      wb_data_o          <= {DW{1'b0}};
      err_o              <= 1'b0;
      err_cause_o        <= 2'b00;
    end else begin
      state_r            <= state_nxt_s;
      ready_r            <= (state_nxt_s == S_IDLE) | (state_nxt_s == S_RESP);
      req_to_dtcm        <= 1'b0;
      load_to_dtcm       <= 1'b0;
      store_to_dtcm      <= 1'b0;
      addr_to_dtcm       <= {AW{1'b0}};
      store_data_to_dtcm <= {DW{1'b0}};
      store_mask_to_dtcm <= 4'b0000;
      wb_valid_o         <= 1'b0;
      wb_we_o            <= 1'b0;
      wb_rd_o            <= 5'd0;
      wb_data_o          <= {DW{1'b0}};
      err_o              <= 1'b0;
      err_cause_o        <= 2'b00;
      if (state_r == S_WAIT && state_nxt_s == S_WAIT) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= {TO_W{1'b0}};
      end
      if (accept_s) begin
        op_load_r     <= ex_load_i;
        op_unsigned_r <= ex_unsigned_i;
        op_size_r     <= ex_size_i;
        op_rd_r       <= ex_rd_i;
        if (state_nxt_s == S_REQ) begin
          req_to_dtcm        <= 1'b1;
          load_to_dtcm       <= ex_load_i;
          store_to_dtcm      <= ex_store_i;
          addr_to_dtcm       <= ex_addr_i;
          store_data_to_dtcm <= ex_store_i ? store_trim(ex_wdata_i, ex_size_i) : {DW{1'b0}};
          store_mask_to_dtcm <= size_to_mask(ex_size_i);
        end else begin
          wb_valid_o  <= 1'b1;
          wb_rd_o     <= ex_rd_i;
          err_o       <= 1'b1;
          err_cause_o <= cause_nxt_s;
        end
      end else if (state_r == S_WAIT && state_nxt_s == S_RESP) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= op_rd_r;
        if (res_from_dtcm) begin
          wb_we_o   <= op_load_r & (op_rd_r != 5'd0);
          wb_data_o <= op_load_r ? load_extend(data_from_dtcm, op_size_r, op_unsigned_r)
                                 : {DW{1'b0}};
        end else begin
          err_o       <= 1'b1;
          err_cause_o <= cause_nxt_s;
        end
      end else begin
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// Directed bench for lsu_dtcm_master: a default instance plus one with CHK_ALIGN=0, TIMEOUT=3.
module tb_lsu_dtcm_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_unsigned = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        res = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic        ready, req, ld, st, wb_valid, wb_we, err;
  logic [31:0] addr, sdata, wb_data;
  logic [3:0]  mask;
  logic [4:0]  wb_rd;
  logic [1:0]  cause;

  logic        ready2, req2, ld2, st2, wb_valid2, wb_we2, err2;
  logic [31:0] addr2, sdata2, wb_data2;
  logic [3:0]  mask2;
  logic [4:0]  wb_rd2;
  logic [1:0]  cause2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_dtcm_master dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ready),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_size_i(ex_size),
    .ex_unsigned_i(ex_unsigned), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
    .req_to_dtcm(req), .load_to_dtcm(ld), .store_to_dtcm(st), .addr_to_dtcm(addr),
    .store_data_to_dtcm(sdata), .store_mask_to_dtcm(mask), .res_from_dtcm(res),
    .data_from_dtcm(rdata), .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .err_o(err), .err_cause_o(cause)
  );

  lsu_dtcm_master #(.CHK_ALIGN(0), .TIMEOUT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ready2),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_size_i(ex_size),
    .ex_unsigned_i(ex_unsigned), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
    .req_to_dtcm(req2), .load_to_dtcm(ld2), .store_to_dtcm(st2), .addr_to_dtcm(addr2),
    .store_data_to_dtcm(sdata2), .store_mask_to_dtcm(mask2), .res_from_dtcm(res),
    .data_from_dtcm(rdata), .wb_valid_o(wb_valid2), .wb_we_o(wb_we2), .wb_rd_o(wb_rd2),
    .wb_data_o(wb_data2), .err_o(err2), .err_cause_o(cause2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns one cycle after acceptance.
  task automatic issue(input logic l, input logic s, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = l; ex_store = s; ex_size = sz; ex_unsigned = u;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] req_seen;
    logic [5:0] wb_seen;
    logic       prev_req;

    tick(); tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    rst_n = 1'b1;
    tick();

    // LB 0x103, signed byte 0xF0
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 5'd5);
    chk("lb_req", 32'(req), 32'd1);
    chk("lb_load", 32'(ld), 32'd1);
    chk("lb_addr", addr, 32'h103);
    chk("lb_ready_busy", 32'(ready), 32'd0);
    tick();
    chk("lb_req_once", 32'(req), 32'd0);
    res = 1'b1; rdata = 32'h000000F0;
    tick();
    res = 1'b0;
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_wb_data", wb_data, 32'hFFFFFFF0);
    chk("lb_wb_we", 32'(wb_we), 32'd1);
    chk("lb_wb_rd", 32'(wb_rd), 32'd5);
    chk("lb_err", 32'(err), 32'd0);
    tick();
    chk("lb_wb_pulse", 32'(wb_valid), 32'd0);

    // LBU same data
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 5'd6);
    tick();
    res = 1'b1; rdata = 32'h000000F0;
    tick();
    res = 1'b0;
    chk("lbu_wb_data", wb_data, 32'h000000F0);
    tick();

    // LH 0x22 signed half
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 5'd9);
    chk("lh_mask", 32'(mask), 32'hC);
    tick();
    res = 1'b1; rdata = 32'h55558001;
    tick();
    res = 1'b0;
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    tick();

    // SH 0x10
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234ABCD, 5'd7);
    chk("sh_req", 32'(req), 32'd1);
    chk("sh_store", 32'(st), 32'd1);
    chk("sh_load", 32'(ld), 32'd0);
    chk("sh_mask", 32'(mask), 32'hC);
    chk("sh_sdata", sdata, 32'h0000ABCD);
    chk("sh_addr", addr, 32'h10);
    tick();
    chk("sh_no_dup_req", 32'(req), 32'd0);
    chk("sh_no_dup_store", 32'(st), 32'd0);
    res = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    res = 1'b0;
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_we", 32'(wb_we), 32'd0);
    chk("sh_wb_data", wb_data, 32'd0);
    tick();

    // LW 0x102: misaligned on dut, normal request on dut2 which then times out after 3 WAIT cycles
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 5'd3);
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_cause", 32'(cause), 32'd1);
    chk("mis_we", 32'(wb_we), 32'd0);
    chk("noalign_req", 32'(req2), 32'd1);
    chk("noalign_addr", addr2, 32'h102);
    tick();
    chk("mis_wb_pulse", 32'(wb_valid), 32'd0);
    tick(); tick();
    chk("to3_not_yet", 32'(wb_valid2), 32'd0);
    tick();
    chk("to3_wb_valid", 32'(wb_valid2), 32'd1);
    chk("to3_cause", 32'(cause2), 32'd2);
    tick();

    // LW 0x200, no response: timeout after 15 WAIT cycles
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 5'd4);
    chk("to_req", 32'(req), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", 32'(wb_valid), 32'd0);
    tick();
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_cause", 32'(cause), 32'd2);
    chk("to_data", wb_data, 32'd0);
    tick();
    res = 1'b1; rdata = 32'h12345678;
    tick();
    res = 1'b0;
    chk("late_res_wb", 32'(wb_valid), 32'd0);
    chk("late_res_ready", 32'(ready), 32'd1);
    tick();
    chk("late_res_wb2", 32'(wb_valid), 32'd0);

    // Load with rd=0
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd0);
    tick();
    res = 1'b1; rdata = 32'h11223344;
    tick();
    res = 1'b0;
    chk("rd0_wb_valid", 32'(wb_valid), 32'd1);
    chk("rd0_we", 32'(wb_we), 32'd0);
    chk("rd0_data", wb_data, 32'h11223344);
    tick();

    // Illegal size and illegal load&store
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 5'd2);
    chk("ill_sz_req", 32'(req), 32'd0);
    chk("ill_sz_cause", 32'(cause), 32'd3);
    chk("ill_sz_err", 32'(err), 32'd1);
    tick();
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 5'd2);
    chk("ill_ls_req", 32'(req), 32'd0);
    chk("ill_ls_cause", 32'(cause), 32'd3);
    tick();

    // Back-to-back SW with ex_valid held: expect REQ,WAIT,RESP,REQ,WAIT,RESP
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_size = 2'b10;
    ex_addr = 32'h40; ex_wdata = 32'hCAFEF00D; ex_rd = 5'd1;
    req_seen = 6'd0; wb_seen = 6'd0; prev_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      req_seen[i] = req;
      wb_seen[i] = wb_valid;
      res = prev_req;
      prev_req = req;
      if (i == 3) chk("b2b_ready_resp", 32'(ready), 32'd0);
      if (i == 4) ex_valid = 1'b0;
    end
    res = 1'b0;
    chk("b2b_req_pattern", 32'(req_seen), 32'h09);
    chk("b2b_wb_pattern", 32'(wb_seen), 32'h24);
    tick();
    chk("b2b_idle_ready", 32'(ready), 32'd1);
    chk("b2b_no_third", 32'(req), 32'd0);

    // Reset while in WAIT
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'd0, 5'd8);
    tick();
    rst_n = 1'b0;
    #2;
    chk("rst_wait_ready", 32'(ready), 32'd1);
    chk("rst_wait_req", 32'(req), 32'd0);
    rst_n = 1'b1;
    tick();
    res = 1'b1; rdata = 32'h0BADF00D;
    tick();
    res = 1'b0;
    chk("rst_wait_no_wb", 32'(wb_valid), 32'd0);
    tick();
    chk("rst_wait_no_wb2", 32'(wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
